// File: rtl/uart_word_pkg.sv
// Shared types and constants for the UART-to-SHA-256 word packer.
package uart_word_pkg;

    // Packing FSM: S_IDLE holds no bytes, S_COLLECT holds 1..3 bytes.
    typedef enum logic {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    localparam int BYTES_PER_WORD  = 4;
    localparam int WORDS_PER_BLOCK = 16;
    localparam int WORD_W          = 32;
    localparam int ENTRY_W         = WORD_W + 1;   // {last, word}

    // True when the word index is the final word of a 512-bit block.
    function automatic logic is_last_word(input logic [3:0] idx);
        return idx == 4'(WORDS_PER_BLOCK - 1);
    endfunction

endpackage

// File: rtl/word_fifo.sv
// First-word-fall-through FIFO with a registered head.
// The head register always holds the oldest entry (or 0 when empty), so
// pop_data is a flop output and is stable until the entry is popped.
module word_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] head_q;

    logic             pop_ok;
    logic             push_ok;
    logic [PW-1:0]    wr_ptr_n;
    logic [PW-1:0]    rd_ptr_n;
    logic [CW-1:0]    cnt_n;
    logic [WIDTH-1:0] head_n;

    assign full     = (cnt_q == CW'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign pop_data = head_q;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Next pointers, occupancy and head value; pointers wrap naturally
    // because DEPTH is a power of two.
    always_comb begin
        wr_ptr_n = wr_ptr_q;
        rd_ptr_n = rd_ptr_q;
        cnt_n    = cnt_q;
        head_n   = head_q;
        if (push_ok) begin
            wr_ptr_n = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_n = rd_ptr_q + PW'(1);
        end
        cnt_n = cnt_q + CW'(push_ok) - CW'(pop_ok);
        if (cnt_n == '0) begin
            head_n = '0;
        end else if (empty || (cnt_q == CW'(1) && pop_ok)) begin
            // The entry being pushed is the only one left: it becomes head.
            head_n = push_data;
        end else begin
            head_n = mem_q[rd_ptr_n];
        end
    end

    // Storage array; contents need no reset because the head register is
    // the only path to the output.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointer, occupancy and head registers with async reset and sync clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_n;
            rd_ptr_q <= rd_ptr_n;
            cnt_q    <= cnt_n;
            head_q   <= head_n;
        end
    end

endmodule

// File: rtl/uart_word_packer.sv
// Packs UART receiver bytes big-endian into 32-bit words, tags every 16th
// word as the end of a SHA-256 message block and buffers words in a FIFO.
//
// Output handshake: Word_Valid_out=1 means Word_out/Word_Last_out hold the
// oldest buffered word; it transfers on a clock edge where Word_Valid_out
// and Word_Ready_in are both 1. While Valid=1 and Ready=0 the word and its
// tag stay unchanged. Ready without Valid does nothing. The UART side has
// no back-pressure: a word that finds the FIFO full is dropped and flagged.
module uart_word_packer
    import uart_word_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int TIMEOUT_CLKS = 17360,
    parameter int TIMEOUT_W    = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        Clear_in,
    input  logic        Rx_DV_in,
    input  logic [7:0]  Rx_Byte_in,
    output logic [31:0] Word_out,
    output logic        Word_Last_out,
    output logic        Word_Valid_out,
    input  logic        Word_Ready_in,
    output logic [3:0]  Word_Count_out,
    output logic        Overflow_Err_out,
    output logic        Timeout_Err_out,
    output state_t      State_dbg_out
);

    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CLKS - 1);
    localparam logic [1:0]           LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    state_t               state_q, state_n;
    logic [23:0]          held_q, held_n;
    logic [1:0]           bcnt_q, bcnt_n;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_n;
    logic [3:0]           wcnt_q;
    logic                 ovf_q;
    logic                 tmo_err_q;

    logic                 push_req;
    logic                 expire;
    logic                 pop;
    logic                 push_ok;
    logic                 drop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [ENTRY_W-1:0]   push_entry;
    logic [ENTRY_W-1:0]   head_entry;

    assign push_entry = {is_last_word(wcnt_q), held_q, Rx_Byte_in};

    assign Word_Valid_out   = !fifo_empty;
    assign Word_out         = head_entry[WORD_W-1:0];
    assign Word_Last_out    = head_entry[ENTRY_W-1];
    assign Word_Count_out   = wcnt_q;
    assign Overflow_Err_out = ovf_q;
    assign Timeout_Err_out  = tmo_err_q;
    assign State_dbg_out    = state_q;

    // Mirrors the FIFO accept rule so the word index only counts real pushes.
    assign pop     = Word_Ready_in && Word_Valid_out;
    assign push_ok = push_req && (!fifo_full || pop);
    assign drop    = push_req && fifo_full && !pop;

    // Packing FSM next state: shift bytes in, push on the 4th, and discard a
    // partial word after TIMEOUT_CLKS idle clocks (a DV always beats expiry).
    always_comb begin
        state_n  = state_q;
        held_n   = held_q;
        bcnt_n   = bcnt_q;
        tmo_n    = tmo_q;
        push_req = 1'b0;
        expire   = 1'b0;
        case (state_q)
            S_IDLE: begin
                tmo_n = '0;
                if (Rx_DV_in) begin
                    held_n  = {held_q[15:0], Rx_Byte_in};
                    bcnt_n  = 2'd1;
                    state_n = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (Rx_DV_in) begin
                    tmo_n = '0;
                    if (bcnt_q == LAST_BYTE) begin
                        push_req = 1'b1;
                        held_n   = '0;
                        bcnt_n   = 2'd0;
                        state_n  = S_IDLE;
                    end else begin
                        held_n = {held_q[15:0], Rx_Byte_in};
                        bcnt_n = bcnt_q + 2'd1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    expire  = 1'b1;
                    held_n  = '0;
                    bcnt_n  = 2'd0;
                    tmo_n   = '0;
                    state_n = S_IDLE;
                end else begin
                    tmo_n = tmo_q + TIMEOUT_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                held_n  = '0;
                bcnt_n  = 2'd0;
                tmo_n   = '0;
            end
        endcase
    end

    // Packer state, word index and error flags; Clear_in wins over any DV.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            held_q    <= '0;
            bcnt_q    <= '0;
            tmo_q     <= '0;
            wcnt_q    <= '0;
            ovf_q     <= 1'b0;
            tmo_err_q <= 1'b0;
        end else if (Clear_in) begin
            state_q   <= S_IDLE;
            held_q    <= '0;
            bcnt_q    <= '0;
            tmo_q     <= '0;
            wcnt_q    <= '0;
            ovf_q     <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            held_q    <= held_n;
            bcnt_q    <= bcnt_n;
            tmo_q     <= tmo_n;
            tmo_err_q <= expire;
            if (push_ok) begin
                wcnt_q <= wcnt_q + 4'd1;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    word_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RST_N),
        .clear     (Clear_in),
        .push      (push_req),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_uart_word_packer.sv
// Directed bench for uart_word_packer: packing, block tagging, overflow,
// full push/pop, timeout and its DV race, clear and async reset.
module tb_uart_word_packer;
    import uart_word_pkg::*;

    localparam int TMO = 17360;

    logic        CLK;
    logic        RST_N;
    logic        Clear_in;
    logic        Rx_DV_in;
    logic [7:0]  Rx_Byte_in;
    logic [31:0] Word_out;
    logic        Word_Last_out;
    logic        Word_Valid_out;
    logic        Word_Ready_in;
    logic [3:0]  Word_Count_out;
    logic        Overflow_Err_out;
    logic        Timeout_Err_out;
    state_t      State_dbg_out;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;

    uart_word_packer #(
        .FIFO_DEPTH   (8),
        .TIMEOUT_CLKS (TMO),
        .TIMEOUT_W    (16)
    ) dut (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .Clear_in         (Clear_in),
        .Rx_DV_in         (Rx_DV_in),
        .Rx_Byte_in       (Rx_Byte_in),
        .Word_out         (Word_out),
        .Word_Last_out    (Word_Last_out),
        .Word_Valid_out   (Word_Valid_out),
        .Word_Ready_in    (Word_Ready_in),
        .Word_Count_out   (Word_Count_out),
        .Overflow_Err_out (Overflow_Err_out),
        .Timeout_Err_out  (Timeout_Err_out),
        .State_dbg_out    (State_dbg_out)
    );

    // Clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Drivers: all called at posedge+1 and return at posedge+1.
    task automatic send_byte(input logic [7:0] b);
        Rx_DV_in   = 1'b1;
        Rx_Byte_in = b;
        @(posedge CLK);
        #1;
        Rx_DV_in   = 1'b0;
        Rx_Byte_in = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_clear();
        Clear_in = 1'b1;
        @(posedge CLK);
        #1;
        Clear_in = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b1; Clear_in = 1'b0; Rx_DV_in = 1'b0; Rx_Byte_in = 8'h00; Word_Ready_in = 1'b0;
        #2 RST_N = 1'b0;
        #2;
        n_checks++;
        if ({Word_out, Word_Last_out, Word_Valid_out, Word_Count_out, Overflow_Err_out, Timeout_Err_out} !== 40'd0) begin
            n_errors++; $display("FAIL reset_outputs: got word=%h last=%b valid=%b cnt=%0d ovf=%b tmo=%b, expected all 0",
                                 Word_out, Word_Last_out, Word_Valid_out, Word_Count_out, Overflow_Err_out, Timeout_Err_out);
        end
        n_checks++;
        if (State_dbg_out !== S_IDLE) begin n_errors++; $display("FAIL reset_state: got %0d expected %0d", State_dbg_out, S_IDLE); end
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        idle_cycles(1);
        n_checks++;
        if (Word_Valid_out !== 1'b0 || Word_Count_out !== 4'd0) begin
            n_errors++; $display("FAIL post_reset: got valid=%b cnt=%0d expected 0 0", Word_Valid_out, Word_Count_out);
        end
    endtask

    task automatic test_single_word();
        Word_Ready_in = 1'b1;
        send_byte(8'h61); send_byte(8'h62); send_byte(8'h63);
        n_checks++;
        if (Word_Valid_out !== 1'b0) begin n_errors++; $display("FAIL single_valid_early: got %b expected 0", Word_Valid_out); end
        send_byte(8'h80);
        n_checks++;
        if (Word_Valid_out !== 1'b1) begin n_errors++; $display("FAIL single_valid: got %b expected 1", Word_Valid_out); end
        n_checks++;
        if (Word_out !== 32'h61626380) begin n_errors++; $display("FAIL single_word: got %h expected 61626380", Word_out); end
        n_checks++;
        if (Word_Last_out !== 1'b0) begin n_errors++; $display("FAIL single_last: got %b expected 0", Word_Last_out); end
        n_checks++;
        if (Word_Count_out !== 4'd1) begin n_errors++; $display("FAIL single_count: got %0d expected 1", Word_Count_out); end
        idle_cycles(1);
        n_checks++;
        if (Word_Valid_out !== 1'b0) begin n_errors++; $display("FAIL single_popped: got valid=%b expected 0", Word_Valid_out); end
    endtask

    task automatic test_clear();
        Word_Ready_in = 1'b1;
        send_byte(8'h77); send_byte(8'h88);
        // Clear coincides with a DV: the byte must be dropped.
        Clear_in = 1'b1; Rx_DV_in = 1'b1; Rx_Byte_in = 8'h55;
        @(posedge CLK);
        #1;
        Clear_in = 1'b0; Rx_DV_in = 1'b0; Rx_Byte_in = 8'h00;
        n_checks++;
        if ({Word_out, Word_Last_out, Word_Valid_out, Word_Count_out, Overflow_Err_out, Timeout_Err_out} !== 40'd0) begin
            n_errors++; $display("FAIL clear_outputs: got word=%h valid=%b cnt=%0d, expected all 0", Word_out, Word_Valid_out, Word_Count_out);
        end
        n_checks++;
        if (State_dbg_out !== S_IDLE) begin n_errors++; $display("FAIL clear_state: got %0d expected %0d", State_dbg_out, S_IDLE); end
        send_word(32'hDEADBEEF);
        n_checks++;
        if (Word_Valid_out !== 1'b1 || Word_out !== 32'hDEADBEEF) begin
            n_errors++; $display("FAIL clear_next_word: got valid=%b word=%h expected 1 deadbeef", Word_Valid_out, Word_out);
        end
        n_checks++;
        if (Word_Count_out !== 4'd1) begin n_errors++; $display("FAIL clear_next_count: got %0d expected 1", Word_Count_out); end
        idle_cycles(1);
    endtask

    task automatic test_block();
        do_clear();
        Word_Ready_in = 1'b1;
        for (int w = 0; w < 16; w++) begin
            exp_w = {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)};
            send_word(exp_w);
            n_checks++;
            if (Word_Valid_out !== 1'b1 || Word_out !== exp_w) begin
                n_errors++; $display("FAIL block_word[%0d]: got valid=%b word=%h expected 1 %h", w, Word_Valid_out, Word_out, exp_w);
            end
            n_checks++;
            if (Word_Last_out !== (w == 15)) begin
                n_errors++; $display("FAIL block_last[%0d]: got %b expected %b", w, Word_Last_out, (w == 15));
            end
            n_checks++;
            if (Word_Count_out !== 4'(w + 1)) begin
                n_errors++; $display("FAIL block_count[%0d]: got %0d expected %0d", w, Word_Count_out, 4'(w + 1));
            end
        end
        idle_cycles(1);
        n_checks++;
        if (Word_Valid_out !== 1'b0 || Word_Count_out !== 4'd0) begin
            n_errors++; $display("FAIL block_end: got valid=%b cnt=%0d expected 0 0", Word_Valid_out, Word_Count_out);
        end
    endtask

    task automatic test_overflow();
        do_clear();
        Word_Ready_in = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            exp_w = {8'(i), 8'hB1, 8'hC2, 8'(8'hD0 + i)};
            if (i < 8) exp_q.push_back(exp_w);
            send_word(exp_w);
            if (i == 7) begin
                n_checks++;
                if (Overflow_Err_out !== 1'b0) begin n_errors++; $display("FAIL ovf_early: got %b expected 0", Overflow_Err_out); end
            end
        end
        n_checks++;
        if (Overflow_Err_out !== 1'b1) begin n_errors++; $display("FAIL ovf_set: got %b expected 1", Overflow_Err_out); end
        n_checks++;
        if (Word_Count_out !== 4'd8) begin n_errors++; $display("FAIL ovf_count: got %0d expected 8", Word_Count_out); end
        idle_cycles(3);
        n_checks++;
        if (Word_Valid_out !== 1'b1 || Word_out !== exp_q[0]) begin
            n_errors++; $display("FAIL ovf_hold: got valid=%b word=%h expected 1 %h", Word_Valid_out, Word_out, exp_q[0]);
        end
        Word_Ready_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_w = exp_q.pop_front();
            n_checks++;
            if (Word_Valid_out !== 1'b1 || Word_out !== exp_w || Word_Last_out !== 1'b0) begin
                n_errors++; $display("FAIL ovf_drain[%0d]: got valid=%b word=%h last=%b expected 1 %h 0",
                                     k, Word_Valid_out, Word_out, Word_Last_out, exp_w);
            end
            idle_cycles(1);
        end
        n_checks++;
        if (Word_Valid_out !== 1'b0 || Overflow_Err_out !== 1'b1) begin
            n_errors++; $display("FAIL ovf_after: got valid=%b ovf=%b expected 0 1", Word_Valid_out, Overflow_Err_out);
        end
    endtask

    task automatic test_full_push_pop();
        do_clear();
        Word_Ready_in = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            exp_w = 32'hC0DE0000 + 32'(i);
            exp_q.push_back(exp_w);
            send_word(exp_w);
        end
        send_byte(8'hC0); send_byte(8'hDE); send_byte(8'h00);
        // 4th byte and a pop land on the same edge while full.
        Word_Ready_in = 1'b1;
        send_byte(8'h08);
        void'(exp_q.pop_front());
        exp_q.push_back(32'hC0DE0008);
        n_checks++;
        if (Overflow_Err_out !== 1'b0) begin n_errors++; $display("FAIL fpp_ovf: got %b expected 0", Overflow_Err_out); end
        n_checks++;
        if (Word_Count_out !== 4'd9) begin n_errors++; $display("FAIL fpp_count: got %0d expected 9", Word_Count_out); end
        for (int k = 0; k < 8; k++) begin
            exp_w = exp_q.pop_front();
            n_checks++;
            if (Word_Valid_out !== 1'b1 || Word_out !== exp_w) begin
                n_errors++; $display("FAIL fpp_drain[%0d]: got valid=%b word=%h expected 1 %h", k, Word_Valid_out, Word_out, exp_w);
            end
            idle_cycles(1);
        end
        n_checks++;
        if (Word_Valid_out !== 1'b0) begin n_errors++; $display("FAIL fpp_empty: got valid=%b expected 0", Word_Valid_out); end
    endtask

    task automatic test_timeout();
        do_clear();
        Word_Ready_in = 1'b1;
        send_byte(8'hAA); send_byte(8'hBB);
        idle_cycles(TMO - 1);
        n_checks++;
        if (Timeout_Err_out !== 1'b0 || State_dbg_out !== S_COLLECT) begin
            n_errors++; $display("FAIL tmo_early: got err=%b state=%0d expected 0 %0d", Timeout_Err_out, State_dbg_out, S_COLLECT);
        end
        idle_cycles(1);
        n_checks++;
        if (Timeout_Err_out !== 1'b1) begin n_errors++; $display("FAIL tmo_pulse: got %b expected 1", Timeout_Err_out); end
        n_checks++;
        if (State_dbg_out !== S_IDLE || Word_Valid_out !== 1'b0) begin
            n_errors++; $display("FAIL tmo_idle: got state=%0d valid=%b expected %0d 0", State_dbg_out, Word_Valid_out, S_IDLE);
        end
        idle_cycles(1);
        n_checks++;
        if (Timeout_Err_out !== 1'b0) begin n_errors++; $display("FAIL tmo_pulse_end: got %b expected 0", Timeout_Err_out); end
        send_word(32'h01020304);
        n_checks++;
        if (Word_Valid_out !== 1'b1 || Word_out !== 32'h01020304 || Word_Count_out !== 4'd1) begin
            n_errors++; $display("FAIL tmo_next_word: got valid=%b word=%h cnt=%0d expected 1 01020304 1",
                                 Word_Valid_out, Word_out, Word_Count_out);
        end
        idle_cycles(1);
    endtask

    task automatic test_timeout_dv_race();
        do_clear();
        Word_Ready_in = 1'b1;
        send_byte(8'h11); send_byte(8'h22);
        idle_cycles(TMO - 1);
        send_byte(8'hCC);   // sampled on the expiry edge
        n_checks++;
        if (Timeout_Err_out !== 1'b0 || State_dbg_out !== S_COLLECT) begin
            n_errors++; $display("FAIL race_no_tmo: got err=%b state=%0d expected 0 %0d", Timeout_Err_out, State_dbg_out, S_COLLECT);
        end
        idle_cycles(1);
        n_checks++;
        if (Timeout_Err_out !== 1'b0) begin n_errors++; $display("FAIL race_no_tmo_late: got %b expected 0", Timeout_Err_out); end
        send_byte(8'hDD);
        n_checks++;
        if (Word_Valid_out !== 1'b1 || Word_out !== 32'h1122CCDD) begin
            n_errors++; $display("FAIL race_word: got valid=%b word=%h expected 1 1122ccdd", Word_Valid_out, Word_out);
        end
        idle_cycles(1);
    endtask

    task automatic test_async_reset();
        do_clear();
        Word_Ready_in = 1'b1;
        send_byte(8'h01); send_byte(8'h02);
        #2 RST_N = 1'b0;
        #1;
        n_checks++;
        if ({Word_out, Word_Last_out, Word_Valid_out, Word_Count_out, Overflow_Err_out, Timeout_Err_out} !== 40'd0
            || State_dbg_out !== S_IDLE) begin
            n_errors++; $display("FAIL rst_midword: got word=%h valid=%b cnt=%0d state=%0d expected all 0",
                                 Word_out, Word_Valid_out, Word_Count_out, State_dbg_out);
        end
        #2 RST_N = 1'b1;
        idle_cycles(1);
        Word_Ready_in = 1'b0;
        send_word(32'hA1A2A3A4); send_word(32'hB1B2B3B4); send_word(32'hC1C2C3C4);
        Word_Ready_in = 1'b1;
        idle_cycles(1);
        n_checks++;
        if (Word_Valid_out !== 1'b1 || Word_out !== 32'hB1B2B3B4 || Word_Count_out !== 4'd3) begin
            n_errors++; $display("FAIL rst_pre_drain: got valid=%b word=%h cnt=%0d expected 1 b1b2b3b4 3",
                                 Word_Valid_out, Word_out, Word_Count_out);
        end
        #2 RST_N = 1'b0;
        #1;
        n_checks++;
        if ({Word_out, Word_Last_out, Word_Valid_out, Word_Count_out, Overflow_Err_out, Timeout_Err_out} !== 40'd0) begin
            n_errors++; $display("FAIL rst_middrain: got word=%h valid=%b cnt=%0d expected all 0", Word_out, Word_Valid_out, Word_Count_out);
        end
        #2 RST_N = 1'b1;
        idle_cycles(1);
        send_word(32'h5A5B5C5D);
        n_checks++;
        if (Word_Valid_out !== 1'b1 || Word_out !== 32'h5A5B5C5D || Word_Last_out !== 1'b0 || Word_Count_out !== 4'd1) begin
            n_errors++; $display("FAIL rst_fresh_word: got valid=%b word=%h last=%b cnt=%0d expected 1 5a5b5c5d 0 1",
                                 Word_Valid_out, Word_out, Word_Last_out, Word_Count_out);
        end
        idle_cycles(1);
    endtask

    // Test sequence and final report
    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_single_word();
        test_clear();
        test_block();
        test_overflow();
        test_full_push_pop();
        test_timeout();
        test_timeout_dv_race();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_word_packer.md
Name: uart_word_packer

Overview:
- Sits directly downstream of the UART receiver. Consumes its 1-cycle byte strobe and byte, packs bytes big-endian into 32-bit words, and tags every 16th word as the end of a 512-bit SHA-256 message block.
- Buffers words in a small FIFO and presents them to the SHA-256 message-schedule loader over a valid/ready handshake.
- The UART cannot be stalled, so overflow and inter-byte timeout are reported, never back-pressured.

Parameters:
- FIFO_DEPTH, 8, word FIFO entries; power of two, minimum 2.
- TIMEOUT_CLKS, 17360, idle clocks after which a partial word is discarded. Default is 20 UART bit times at 868 clocks per bit.
- TIMEOUT_W, 16, timeout counter width; must satisfy 2^TIMEOUT_W > TIMEOUT_CLKS.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  reset, asynchronous, active-low
- Clear_in  in  1  synchronous flush of all state
- Rx_DV_in  in  1  byte-valid strobe from receiver, 1 cycle wide
- Rx_Byte_in  in  8  received byte, valid when Rx_DV_in=1
- Word_out  out  32  head-of-FIFO word
- Word_Last_out  out  1  head word is word 15 of its block
- Word_Valid_out  out  1  FIFO non-empty
- Word_Ready_in  in  1  consumer accepts; pop happens when Valid and Ready are both 1
- Word_Count_out  out  4  index (0..15) of the next word to be pushed
- Overflow_Err_out  out  1  sticky: a word was dropped because the FIFO was full
- Timeout_Err_out  out  1  1-cycle pulse when a partial word is discarded

Behaviour:
- Reset (RST_N=0, asynchronous):
  - FSM goes to S_IDLE; byte counter, word count and FIFO pointers are 0.
  - All outputs are 0, including Word_out.
- Clear_in=1: same effect as reset, but synchronous at the next edge. Clear has priority over every other event in that cycle; a DV in the same cycle is dropped.
- Packing:
  - The first byte of a word goes to bits [31:24], the 4th byte to bits [7:0].
  - The 3 held bytes sit in a 24-bit register; a 2-bit byte counter runs 0..3.
- FSM:
  - S_IDLE (byte count 0): a DV stores the byte, count becomes 1, go to S_COLLECT.
  - S_COLLECT: a DV with count<3 stores the byte and increments count. A DV with count=3 pushes {held[23:0], Rx_Byte_in} in the same cycle, sets count to 0 and returns to S_IDLE.
  - S_COLLECT timeout: the counter clears on every DV and increments otherwise. If it reaches TIMEOUT_CLKS-1 without a DV, the held bytes are discarded, Timeout_Err_out pulses for 1 cycle, and the FSM goes to S_IDLE.
  - If a DV and timeout expiry coincide, the DV wins: the byte is accepted and there is no error.
  - The timeout counter is held at 0 in S_IDLE.
- Word push:
  - The FIFO entry is 33 bits: {last, word}, with last = (Word_Count_out==15).
  - Word_Count_out increments modulo 16 on every successful push only. Dropped words do not advance it.
- FIFO:
  - First-word-fall-through with a registered output.
  - A word pushed at edge N is visible at Word_out/Word_Valid_out after edge N. Latency from the 4th DV to Valid is 1 cycle when the FIFO is empty.
- Full FIFO:
  - A push while full with no pop in the same cycle drops the word and sets Overflow_Err_out. Overflow_Err_out is cleared only by reset or Clear_in.
  - A push and pop in the same cycle while full are both performed, and occupancy is unchanged.
- Empty FIFO: Ready with Valid=0 has no effect. Pointers wrap modulo FIFO_DEPTH.
- Word_out and Word_Last_out are held stable while Valid=1 and Ready=0.

Decomposition:
- Package uart_word_pkg:
  - state encoding S_IDLE=1'b0, S_COLLECT=1'b1
  - BYTES_PER_WORD=4, WORDS_PER_BLOCK=16, FIFO entry width 33
- Sub-module word_fifo:
  - synchronous FWFT FIFO, parameters WIDTH and DEPTH
  - ports: push/data, pop/data, full, empty
  - async active-low reset plus sync clear
- The packing FSM and timeout counter stay in the top level.

Test Plan:
- Bytes 0x61,0x62,0x63,0x80 with Ready=1 -> one word 0x61626380 with Last=0. Valid rises 1 cycle after the 4th DV; Word_Count_out=1.
- 64 bytes 0x00..0x3F with Ready=1 -> 16 words, first 0x00010203 and last 0x3C3D3E3F. Last=1 only on word 15; Word_Count_out wraps to 0.
- Ready=0, 9 words sent (FIFO_DEPTH=8) -> 8 words buffered and Overflow_Err_out=1 after the 9th. Raising Ready drains words 0..7 in order; the 9th word never appears.
- Two bytes 0xAA,0xBB, then idle 17360 clocks -> one-cycle Timeout_Err_out and nothing pushed. Next bytes 0x01..0x04 -> word 0x01020304.
- DV with 0xCC exactly on the timeout-expiry cycle -> no Timeout_Err_out and the byte is kept as byte 3.
- RST_N pulsed low mid-word (count=2) and mid-drain -> all outputs 0 immediately. Next 4 bytes form a fresh word with index 0.
